// File: rtl/hex_display_sequencer.sv
// Binary to decimal 7-segment sequencer: double-dabble, scanned decode, atomic commit.
// Define LEADING_ZERO_BLANK_EN to blank zero digits above the most significant digit.
module hex_display_sequencer #(
  parameter int BIN_W = 20,
  parameter int NDIG  = 6
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic [BIN_W-1:0]  bin_in,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [NDIG*7-1:0] hex_out
);

  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int BW = NDIG * 4;
  localparam int HW = NDIG * 7;
  localparam logic [BIN_W-1:0] MAX_VAL = BIN_W'(10**NDIG - 1);
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [HW-1:0] RST_PAT = {{(NDIG-1){7'h7F}}, 7'h40};
`else
  localparam logic [HW-1:0] RST_PAT = {NDIG{7'h40}};
`endif

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SCAN,
    COMMIT
  } state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic [HW-1:0]    shadow_q, shadow_d;
  logic [HW-1:0]    hex_q, hex_d;
  logic             done_q, done_d;
  logic [BW-1:0]    adj;
  logic [3:0]       nib;
  logic [6:0]       seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [NDIG-1:0] lz;
  logic            zero_above;

  // Digit i is a leading zero when it and every higher digit are zero.
  always_comb begin
    lz = '0;
    zero_above = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_above = zero_above & (bcd_q[i*4 +: 4] == 4'd0);
      lz[i] = zero_above & (i != 0);
    end
  end
`endif

  always_comb begin
    nib = bcd_q[idx_q*4 +: 4];
    if (ovf_q) begin
      seg = SEG_DASH;
    end else begin
      seg = seg7(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (lz[idx_q]) begin
        seg = SEG_BLANK;
      end
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    shadow_d = shadow_q;
    hex_d    = hex_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = CONV;
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = CW'(BIN_W - 1);
          ovf_d   = (bin_in > MAX_VAL);
        end
      end
      CONV: begin
        {bcd_d, bin_d} = {adj[BW-2:0], bin_q, 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        shadow_d[idx_q*7 +: 7] = seg;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NDIG - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        hex_d   = shadow_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
      shadow_q <= RST_PAT;
      hex_q    <= RST_PAT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
      done_q   <= done_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign hex_out  = hex_q;

endmodule
